// File: rtl/period_meas_if.sv
// Bundles the edge/clear inputs and the measurement outputs of period_meas.
// The slave modport is the measuring block; the master modport is its user.
interface period_meas_if #(
  parameter int CNT_W = 16
);
  logic             edge_in;
  logic             clr;
  logic [CNT_W-1:0] period;
  logic             period_valid;
  logic             glitch;
  logic             overflow;
  logic             measuring;

  modport slave (
    input  edge_in,
    input  clr,
    output period,
    output period_valid,
    output glitch,
    output overflow,
    output measuring
  );

  modport master (
    output edge_in,
    output clr,
    input  period,
    input  period_valid,
    input  glitch,
    input  overflow,
    input  measuring
  );
endinterface

// File: rtl/period_meas.sv
// Counts clk cycles between accepted rising-edge pulses, rejects edges closer than
// MIN_PERIOD and flags loss of input once the counter reaches its ceiling.
module period_meas #(
  parameter int CNT_W      = 16,
  parameter int MIN_PERIOD = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  period_meas_if.slave pm
);

  typedef enum logic {IDLE, MEASURE} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] MIN_CNT = CNT_W'(MIN_PERIOD);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [CNT_W-1:0] period_p1, period_nxt;
  logic             vld_p1, vld_nxt;
  logic             glitch_p1, glitch_nxt;
  logic             ovf_p1, ovf_nxt;
  logic             meas_p1;

  // Saturating increment: the cycle counter parks at its ceiling instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? CNT_MAX : v + CNT_W'(1);
  endfunction

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    period_nxt = period_p1;
    vld_nxt    = 1'b0;
    glitch_nxt = 1'b0;
    ovf_nxt    = ovf_p1;
    if (pm.clr) begin
      // Clear wins over a coincident edge, which is simply dropped.
      state_nxt  = IDLE;
      cnt_nxt    = '0;
      period_nxt = '0;
      ovf_nxt    = 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          cnt_nxt = '0;
          if (pm.edge_in) begin
            state_nxt = MEASURE;
            cnt_nxt   = CNT_W'(1);
          end
        end
        MEASURE: begin
          if (pm.edge_in && (cnt >= MIN_CNT)) begin
            period_nxt = cnt;
            vld_nxt    = 1'b1;
            cnt_nxt    = CNT_W'(1);
          end else if (pm.edge_in) begin
            glitch_nxt = 1'b1;
            cnt_nxt    = sat_inc(cnt);
          end else if (cnt == CNT_MAX) begin
            ovf_nxt   = 1'b1;
            state_nxt = IDLE;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = sat_inc(cnt);
          end
        end
        default: begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  // Stage p1: every output comes straight from a register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      period_p1 <= '0;
      vld_p1    <= 1'b0;
      glitch_p1 <= 1'b0;
      ovf_p1    <= 1'b0;
      meas_p1   <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      period_p1 <= period_nxt;
      vld_p1    <= vld_nxt;
      glitch_p1 <= glitch_nxt;
      ovf_p1    <= ovf_nxt;
      meas_p1   <= (state_nxt == MEASURE);
    end
  end

  assign pm.period       = period_p1;
  assign pm.period_valid = vld_p1;
  assign pm.glitch       = glitch_p1;
  assign pm.overflow     = ovf_p1;
  assign pm.measuring    = meas_p1;

endmodule

// File: tb/tb_period_meas.sv
// Self-checking bench for period_meas: a time-stamp reference model checks every
// cycle, plus a table of edge spacings and hand-written corner-case sequences.
module tb_period_meas;

  localparam int CNT_W = 8;
  localparam int MIN_P = 4;
  localparam int MAXC  = (1 << CNT_W) - 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  period_meas_if #(.CNT_W(CNT_W)) pm_if ();

  period_meas #(.CNT_W(CNT_W), .MIN_PERIOD(MIN_P)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .pm   (pm_if)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: remembers the cycle index of the last accepted edge.
  bit armed;
  int t_now = 0;
  int t_ref = 0;
  int exp_period;
  bit exp_valid, exp_glitch, exp_ovf;

  typedef struct {
    int   spacing;
    logic exp_valid;
    logic exp_glitch;
    int   exp_period;
  } vec_t;

  task automatic chk(input string nm, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, req, $time);
    end
  endtask

  task automatic model_reset();
    armed      = 1'b0;
    exp_period = 0;
    exp_valid  = 1'b0;
    exp_glitch = 1'b0;
    exp_ovf    = 1'b0;
  endtask

  task automatic model_step(input bit e, input bit c);
    int sp;
    exp_valid  = 1'b0;
    exp_glitch = 1'b0;
    if (c) begin
      armed      = 1'b0;
      exp_period = 0;
      exp_ovf    = 1'b0;
    end else if (!armed) begin
      if (e) begin
        armed = 1'b1;
        t_ref = t_now;
      end
    end else begin
      sp = t_now - t_ref;
      if (e && sp >= MIN_P) begin
        exp_period = sp;
        exp_valid  = 1'b1;
        t_ref      = t_now;
      end else if (e) begin
        exp_glitch = 1'b1;
      end else if (sp >= MAXC) begin
        exp_ovf = 1'b1;
        armed   = 1'b0;
      end
    end
  endtask

  task automatic check_all();
    chk("model period",   int'(pm_if.period),       exp_period);
    chk("model valid",    int'(pm_if.period_valid), int'(exp_valid));
    chk("model glitch",   int'(pm_if.glitch),       int'(exp_glitch));
    chk("model overflow", int'(pm_if.overflow),     int'(exp_ovf));
    chk("model measuring",int'(pm_if.measuring),    int'(armed));
  endtask

  // Drive one cycle of inputs, advance the model, sample #1 after the edge.
  task automatic tick(input bit e, input bit c);
    pm_if.edge_in = e;
    pm_if.clr     = c;
    if (rst_n) model_step(e, c);
    else       model_reset();
    t_now++;
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0);
  endtask

  task automatic check_outs(input string nm, input int v, input int g, input int p,
                            input int o, input int m);
    chk({nm, " valid"},     int'(pm_if.period_valid), v);
    chk({nm, " glitch"},    int'(pm_if.glitch),       g);
    chk({nm, " period"},    int'(pm_if.period),       p);
    chk({nm, " overflow"},  int'(pm_if.overflow),     o);
    chk({nm, " measuring"}, int'(pm_if.measuring),    m);
  endtask

  vec_t vecs[6];

  initial begin
    vecs[0] = '{10,  1'b1, 1'b0, 10};
    vecs[1] = '{MIN_P, 1'b1, 1'b0, MIN_P};
    vecs[2] = '{MIN_P - 1, 1'b0, 1'b1, 0};
    vecs[3] = '{MAXC, 1'b1, 1'b0, MAXC};
    vecs[4] = '{1,   1'b0, 1'b1, 0};
    vecs[5] = '{37,  1'b1, 1'b0, 37};

    pm_if.edge_in = 1'b0;
    pm_if.clr     = 1'b0;
    model_reset();

    // Reset held while edge_in toggles: everything stays zero.
    for (int i = 0; i < 6; i++) tick(i[0], 1'b0);
    check_outs("reset", 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    idle(20);
    check_outs("post-reset idle", 0, 0, 0, 0, 0);

    // Edges 10 cycles apart: arming edge yields no strobe.
    tick(1'b1, 1'b0);
    check_outs("arm edge", 0, 0, 0, 0, 1);
    idle(9); tick(1'b1, 1'b0);
    check_outs("second edge", 1, 0, 10, 0, 1);
    idle(9); tick(1'b1, 1'b0);
    check_outs("third edge", 1, 0, 10, 0, 1);

    // Edges at 0, 2, 10: the middle one is a glitch and does not restart counting.
    tick(1'b0, 1'b1);
    tick(1'b1, 1'b0);
    idle(1); tick(1'b1, 1'b0);
    check_outs("glitch edge", 0, 1, 0, 0, 1);
    idle(7); tick(1'b1, 1'b0);
    check_outs("after glitch", 1, 0, 10, 0, 1);

    // Table of spacings between an arming edge and the next edge.
    foreach (vecs[k]) begin
      tick(1'b0, 1'b1);
      tick(1'b1, 1'b0);
      idle(vecs[k].spacing - 1);
      tick(1'b1, 1'b0);
      check_outs($sformatf("spacing %0d", vecs[k].spacing), int'(vecs[k].exp_valid),
                 int'(vecs[k].exp_glitch), vecs[k].exp_period, 0, 1);
    end

    // Loss of input: overflow exactly MAXC cycles after the last edge, then sticky.
    tick(1'b0, 1'b1);
    tick(1'b1, 1'b0);
    idle(MAXC - 1);
    check_outs("pre-overflow", 0, 0, 0, 0, 1);
    idle(1);
    check_outs("overflow", 0, 0, 0, 1, 0);
    idle(33);
    tick(1'b1, 1'b0);
    check_outs("rearm after ovf", 0, 0, 0, 1, 1);
    idle(9); tick(1'b1, 1'b0);
    check_outs("period after ovf", 1, 0, 10, 1, 1);
    tick(1'b0, 1'b1);
    check_outs("clr drops ovf", 0, 0, 0, 0, 0);

    // clr coincident with an edge while measuring.
    tick(1'b1, 1'b0);
    idle(5); tick(1'b1, 1'b0);
    idle(3);
    tick(1'b1, 1'b1);
    check_outs("clr+edge", 0, 0, 0, 0, 0);

    // Reset pulse mid-measurement: next edge only re-arms.
    tick(1'b1, 1'b0);
    idle(3);
    rst_n = 1'b0;
    tick(1'b0, 1'b0);
    check_outs("async reset", 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    idle(4);
    tick(1'b1, 1'b0);
    check_outs("edge after reset", 0, 0, 0, 0, 1);
    idle(5); tick(1'b1, 1'b0);
    check_outs("period after reset", 1, 0, 6, 0, 1);

    // Randomized bursts of varying edge density, including long silent gaps.
    for (int b = 0; b < 40; b++) begin
      int mode, len;
      mode = $urandom_range(0, 3);
      len  = $urandom_range(50, 300);
      if (b == 20) begin
        rst_n = 1'b0;
        tick(1'b0, 1'b0);
        rst_n = 1'b1;
      end
      for (int i = 0; i < len; i++) begin
        bit e, c;
        unique case (mode)
          0:       e = ($urandom_range(0, 2) == 0);
          1:       e = ($urandom_range(0, 9) == 0);
          2:       e = 1'b0;
          default: e = ($urandom_range(0, 1) == 0);
        endcase
        c = ($urandom_range(0, 299) == 0);
        tick(e, c);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
